// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial sequence detector:
// controller state encoding and the derived config-length width.
package seq_det_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ARMED = 2'b01;
  localparam logic [1:0] SHIFT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_ARMED = ARMED,
    ST_SHIFT = SHIFT
  } state_t;

  // cfg_len must be able to hold PAT_W itself, hence the extra bit.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial pattern matcher: shift history, fill tracking and a
// length-masked compare against the configured pattern.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             data_bit,
  input  logic             clear,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             match
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] hist_reg;
  logic [PAT_W-1:0] hist_next;
  logic [LEN_W-1:0] fill_reg;
  logic [LEN_W-1:0] fill_next;
  logic [PAT_W-1:0] len_mask;

  // Only the low cfg_len bits of history take part in the compare.
  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign len_mask[gi] = (gi < int'(cfg_len));
    end
  endgenerate

  // Next history/fill for the incoming bit and the match decision on them.
  always_comb begin
    hist_next = {hist_reg[PAT_W-2:0], data_bit};
    fill_next = (fill_reg == FILL_MAX) ? FILL_MAX : fill_reg + LEN_W'(1);
    match     = bit_valid && (cfg_len != '0) && (fill_next >= cfg_len) &&
                (((hist_next ^ cfg_pattern) & len_mask) == '0);
  end

  // History and fill advance per consumed bit; non-overlap forces a refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (clear) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (bit_valid) begin
      hist_reg <= hist_next;
      fill_reg <= (match && !cfg_overlap) ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequence-detector controller: config registers, IDLE/ARMED/SHIFT word
// serializer with valid/ready intake, saturating match counter and a
// sticky threshold interrupt around seq_match_core.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter  int PAT_W  = 8,
  parameter  int WORD_W = 8,
  parameter  int CNT_W  = 16,
  localparam int LEN_W  = len_w(PAT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              irq,
  input  logic              irq_clr
);

  localparam int                IDX_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(PAT_W);

  state_t             state_reg, state_next;
  logic [WORD_W-1:0]  word_reg, word_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               stop_seen_reg, stop_seen_next;

  logic [PAT_W-1:0]   cfg_pattern_reg;
  logic [LEN_W-1:0]   cfg_len_reg;
  logic               cfg_overlap_reg;
  logic [CNT_W-1:0]   cfg_thresh_reg;

  logic [CNT_W-1:0]   match_cnt_reg;
  logic [CNT_W-1:0]   cnt_inc;
  logic               match_pulse_reg;
  logic               irq_reg;
  logic               irq_set;

  logic               bit_valid;
  logic               data_bit;
  logic               core_clear;
  logic               core_match;

  // FSM state and serializer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      word_reg      <= '0;
      idx_reg       <= '0;
      stop_seen_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      word_reg      <= word_next;
      idx_reg       <= idx_next;
      stop_seen_reg <= stop_seen_next;
    end
  end

  // Next-state, handshake and bit-serializer control.
  always_comb begin
    state_next     = state_reg;
    word_next      = word_reg;
    idx_next       = idx_reg;
    stop_seen_next = stop_seen_reg;
    in_ready       = (state_reg == ST_ARMED);
    busy           = (state_reg != ST_IDLE);
    bit_valid      = 1'b0;
    core_clear     = 1'b0;
    data_bit       = word_reg[idx_reg];
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next     = ST_ARMED;
          core_clear     = 1'b1;
          stop_seen_next = 1'b0;
        end
      end
      ST_ARMED: begin
        // stop wins over a same-cycle handshake; the word is left unaccepted
        if (stop) begin
          state_next = ST_IDLE;
        end else if (in_valid) begin
          word_next      = in_data;
          idx_next       = IDX_W'(WORD_W - 1);
          stop_seen_next = 1'b0;
          state_next     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bit_valid = 1'b1;
        if (stop) begin
          stop_seen_next = 1'b1;
        end
        if (idx_reg == '0) begin
          state_next = (stop_seen_reg || stop) ? ST_IDLE : ST_ARMED;
        end else begin
          idx_next = idx_reg - IDX_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Configuration is only writable while idle; over-long lengths clamp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_pattern_reg <= '0;
      cfg_len_reg     <= '0;
      cfg_overlap_reg <= 1'b0;
      cfg_thresh_reg  <= '0;
    end else if (cfg_we && (state_reg == ST_IDLE)) begin
      cfg_pattern_reg <= cfg_pattern;
      cfg_len_reg     <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      cfg_overlap_reg <= cfg_overlap;
      cfg_thresh_reg  <= cfg_thresh;
    end
  end

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .bit_valid   (bit_valid),
    .data_bit    (data_bit),
    .clear       (core_clear),
    .cfg_pattern (cfg_pattern_reg),
    .cfg_len     (cfg_len_reg),
    .cfg_overlap (cfg_overlap_reg),
    .match       (core_match)
  );

  // Saturating increment and threshold-hit detection for this match.
  always_comb begin
    cnt_inc = (match_cnt_reg == CNT_MAX) ? CNT_MAX : match_cnt_reg + CNT_W'(1);
    irq_set = core_match && (cfg_thresh_reg != '0) && (cnt_inc == cfg_thresh_reg);
  end

  // Match counter, registered pulse and sticky irq (set beats clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt_reg   <= '0;
      match_pulse_reg <= 1'b0;
      irq_reg         <= 1'b0;
    end else begin
      match_pulse_reg <= core_match;
      if (core_clear) begin
        match_cnt_reg <= '0;
      end else if (core_match) begin
        match_cnt_reg <= cnt_inc;
      end
      if (irq_set) begin
        irq_reg <= 1'b1;
      end else if (irq_clr) begin
        irq_reg <= 1'b0;
      end
    end
  end

  assign match_pulse = match_pulse_reg;
  assign match_cnt   = match_cnt_reg;
  assign irq         = irq_reg;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: a table of single-run scenarios
// plus hand-written sequences for timing, irq, stop, config lock and reset.
module tb_seq_detect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_pattern = '0;
  logic [3:0]  cfg_len = '0;
  logic        cfg_overlap = 1'b0;
  logic [15:0] cfg_thresh = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        busy;
  logic        match_pulse;
  logic [15:0] match_cnt;
  logic        irq;
  logic        irq_clr = 1'b0;

  seq_detect_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_thresh  (cfg_thresh),
    .start       (start),
    .stop        (stop),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_cnt   (match_cnt),
    .irq         (irq),
    .irq_clr     (irq_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulse_total = 0;
  int pulse_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst && match_pulse === 1'b1) begin
      pulse_total++;
      pulse_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    int         nw;
    logic [7:0] w0;
    logic [7:0] w1;
    int         exp;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] pat, input logic [3:0] len,
                           input logic ov, input logic [15:0] thr);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_thresh = thr;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic accept_word(input logic [7:0] w, output int acc);
    int k = 0;
    while (!in_ready && k < 40) begin
      tick();
      k++;
    end
    check("ready_wait", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    acc = cyc;
    $display("word %02h accepted at cycle %0d", w, acc);
  endtask

  task automatic send_word(input logic [7:0] w);
    int acc;
    accept_word(w, acc);
    for (int i = 0; i < 8; i++) tick();
  endtask

  initial begin
    int p0, a, b, c0, c1;

    //            pat    len    ov  nw  w0     w1     exp
    tbl[0]  = '{8'h0B, 4'd4,  0,  1, 8'hBB, 8'h00, 2};
    tbl[1]  = '{8'h0B, 4'd4,  1,  1, 8'hBB, 8'h00, 2};
    tbl[2]  = '{8'h0B, 4'd4,  1,  1, 8'h5B, 8'h00, 2};
    tbl[3]  = '{8'h0B, 4'd4,  0,  1, 8'h5B, 8'h00, 1};
    tbl[4]  = '{8'h0B, 4'd4,  1,  2, 8'h5B, 8'h60, 3};
    tbl[5]  = '{8'h0B, 4'd4,  0,  2, 8'h5B, 8'h60, 2};
    tbl[6]  = '{8'hA6, 4'd3,  0,  2, 8'h03, 8'h00, 1};
    tbl[7]  = '{8'hFF, 4'd0,  1,  2, 8'hFF, 8'hFF, 0};
    tbl[8]  = '{8'hFF, 4'd15, 1,  2, 8'hFF, 8'hFF, 9};
    tbl[9]  = '{8'hFF, 4'd8,  0,  2, 8'hFF, 8'hFF, 2};
    tbl[10] = '{8'h01, 4'd2,  0,  1, 8'h55, 8'h00, 4};
    tbl[11] = '{8'h01, 4'd1,  0,  1, 8'hA0, 8'h00, 2};

    // reset state while rst is held low
    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pulse", match_pulse, 1'b0);
    check("rst_cnt", match_cnt, 16'd0);
    check("rst_irq", irq, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // table-driven scenarios
    for (int v = 0; v < 12; v++) begin
      configure(tbl[v].pat, tbl[v].len, tbl[v].ov, 16'd0);
      do_start();
      p0 = pulse_total;
      send_word(tbl[v].w0);
      if (tbl[v].nw > 1) send_word(tbl[v].w1);
      do_stop();
      check($sformatf("vec%0d_cnt", v), match_cnt, tbl[v].exp);
      check($sformatf("vec%0d_pulses", v), pulse_total - p0, tbl[v].exp);
      $display("vec %0d: pat=%02h len=%0d ov=%0b cnt=%0d", v, tbl[v].pat, tbl[v].len,
               tbl[v].ov, match_cnt);
    end

    // pulse timing: non-overlap 1011 on 1011_1011 -> pulses 4 and 8 cycles after accept
    configure(8'h0B, 4'd4, 1'b0, 16'd0);
    do_start();
    pulse_cyc.delete();
    accept_word(8'hBB, a);
    for (int i = 0; i < 8; i++) tick();
    do_stop();
    c0 = (pulse_cyc.size() > 0) ? pulse_cyc[0] - a : -1;
    c1 = (pulse_cyc.size() > 1) ? pulse_cyc[1] - a : -1;
    check("spacing_npulses", pulse_cyc.size(), 2);
    check("spacing_first", c0, 4);
    check("spacing_second", c1, 8);

    // boundary-spanning match lands on the first bit of word 2
    configure(8'hA6, 4'd3, 1'b0, 16'd0);
    do_start();
    send_word(8'h03);
    pulse_cyc.delete();
    accept_word(8'h00, b);
    for (int i = 0; i < 8; i++) tick();
    do_stop();
    c0 = (pulse_cyc.size() > 0) ? pulse_cyc[0] - b : -1;
    check("span_npulses", pulse_cyc.size(), 1);
    check("span_bit1", c0, 1);

    // irq at threshold 2; clear coinciding with the 3rd match wins
    configure(8'h0B, 4'd4, 1'b1, 16'd2);
    do_start();
    accept_word(8'hBB, a);
    for (int i = 0; i < 4; i++) tick();
    check("irq_cnt1", match_cnt, 16'd1);
    check("irq_low_at1", irq, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("irq_cnt2", match_cnt, 16'd2);
    check("irq_rise", irq, 1'b1);
    accept_word(8'h60, b);
    check("irq_hold", irq, 1'b1);
    tick();
    tick();
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("irq_clr_3rd", irq, 1'b0);
    check("irq_cnt3", match_cnt, 16'd3);
    check("irq_pulse3", match_pulse, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    do_stop();

    // stop beats a same-cycle handshake in ARMED
    configure(8'h0B, 4'd4, 1'b0, 16'd0);
    do_start();
    stop = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    tick();
    stop = 1'b0; in_valid = 1'b0;
    check("stop_prio_busy", busy, 1'b0);

    // stop mid-word: remaining bits still consumed, then IDLE
    do_start();
    accept_word(8'h0B, a);
    for (int i = 0; i < 3; i++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("stop_still_busy", busy, 1'b1);
    tick();
    check("stop_idle_busy", busy, 1'b0);
    check("stop_idle_ready", in_ready, 1'b0);
    check("stop_last_match", match_cnt, 16'd1);

    // cfg_we during SHIFT must not change the active pattern
    configure(8'h0B, 4'd4, 1'b1, 16'd0);
    do_start();
    accept_word(8'h00, a);
    tick();
    tick();
    cfg_we = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd4; cfg_overlap = 1'b1;
    tick();
    cfg_we = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("cfglock_zeros", match_cnt, 16'd0);
    send_word(8'hB0);
    check("cfglock_old_pat", match_cnt, 16'd1);
    do_stop();

    // asynchronous reset mid-word
    configure(8'h03, 4'd2, 1'b1, 16'd2);
    do_start();
    accept_word(8'hFF, a);
    for (int i = 0; i < 4; i++) tick();
    check("arst_pre_cnt", match_cnt, 16'd3);
    check("arst_pre_irq", irq, 1'b1);
    #3 rst = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_ready", in_ready, 1'b0);
    check("arst_cnt", match_cnt, 16'd0);
    check("arst_irq", irq, 1'b0);
    check("arst_pulse", match_pulse, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
